fetch_queue: RTL and testbench

//  Instruction fetch queue directly downstream of the PC register in the dual-issue front end.

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fetch_queue_ram.sv | 36 +++
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the dual-issue instruction fetch queue.
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          FQ_DEPTH     = 8;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;

    // Number of slots in the valid prefix of a 2-bit slot mask: 00->0, x1->1 or 2, 10->0.
    function automatic logic [1:0] prefix_count(input logic [1:0] v);
        logic [1:0] n;
        n = 2'd0;
        if (v[0]) begin
            n = v[1] ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH entries, two write ports, two asynchronous read ports.
// Contents are not reset; validity is tracked by the pointer logic in fetch_queue.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_we0,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr0,
    input  fetch_entry_t               i_wdata0,
    input  logic                       i_we1,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr1,
    input  fetch_entry_t               i_wdata1,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr0,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr1,
    output fetch_entry_t               o_rdata0,
    output fetch_entry_t               o_rdata1
);

    fetch_entry_t r_mem [DEPTH];

    // Both write ports target distinct consecutive addresses, so no port priority is needed.
    always_ff @(posedge i_clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC register and decode.
// Accepts up to two instructions per cycle, presents the two oldest to decode,
// and raises o_in_ready only when a full fetch pair can be absorbed.
// Optional build macro FETCHQ_PERF_EN adds the o_stall_cycles counter.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = FQ_DEPTH,
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = PC_RESET_VEC
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic [1:0]                 i_in_valid,
    input  logic [WIDTH-1:0]           i_in_inst0,
    input  logic [WIDTH-1:0]           i_in_inst1,
    input  logic [WIDTH-1:0]           i_in_pc,
    output logic                       o_in_ready,
    output logic [1:0]                 o_out_valid,
    output logic [WIDTH-1:0]           o_out_inst0,
    output logic [WIDTH-1:0]           o_out_inst1,
    output logic [WIDTH-1:0]           o_out_pc0,
    output logic [WIDTH-1:0]           o_out_pc1,
    input  logic [1:0]                 i_out_take,
    output logic [$clog2(DEPTH):0]     o_count
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]                o_stall_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic           w_in_ready;
    logic [1:0]     w_out_valid;
    logic [1:0]     w_wr_cnt;
    logic [1:0]     w_rd_cnt;
    logic           w_we0;
    logic           w_we1;
    fetch_entry_t   w_wdata0;
    fetch_entry_t   w_wdata1;
    fetch_entry_t   w_rdata0;
    fetch_entry_t   w_rdata1;
    logic [AW-1:0]  w_head_next;
    logic [AW-1:0]  w_tail_next;
    logic [CW-1:0]  w_count_next;

    // Ready is a function of registered occupancy only, so decode never reaches fetch combinationally.
    assign w_in_ready  = (r_count <= CW'(DEPTH - 2));
    assign w_out_valid = {(r_count >= CW'(2)), (r_count >= CW'(1))};

    // Illegal In_Valid=10 collapses to zero writes; Out_Take is trimmed to its valid prefix.
    assign w_wr_cnt = w_in_ready ? prefix_count(i_in_valid) : 2'd0;
    assign w_rd_cnt = prefix_count(i_out_take & w_out_valid);

    assign w_we0 = !i_flush && (w_wr_cnt != 2'd0);
    assign w_we1 = !i_flush && (w_wr_cnt == 2'd2);

    assign w_wdata0 = '{pc: i_in_pc, inst: i_in_inst0};
    assign w_wdata1 = '{pc: i_in_pc + WIDTH'(4), inst: i_in_inst1};

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we0    (w_we0),
        .i_waddr0 (r_tail),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_we1),
        .i_waddr1 (r_tail + AW'(1)),
        .i_wdata1 (w_wdata1),
        .i_raddr0 (r_head),
        .i_raddr1 (r_head + AW'(1)),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    // Next pointer/occupancy: flush wins over any same-cycle read or write.
    always_comb begin
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        if (i_flush) begin
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end else begin
            w_head_next  = r_head + AW'(w_rd_cnt);
            w_tail_next  = r_tail + AW'(w_wr_cnt);
            w_count_next = r_count + CW'(w_wr_cnt) - CW'(w_rd_cnt);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
        end
    end

    // Head entries go straight to decode; empty slots show 0 / the reset PC.
    always_comb begin
        o_out_inst0 = '0;
        o_out_inst1 = '0;
        o_out_pc0   = PC_RESET;
        o_out_pc1   = PC_RESET;
        if (w_out_valid[0]) begin
            o_out_inst0 = w_rdata0.inst;
            o_out_pc0   = w_rdata0.pc;
        end
        if (w_out_valid[1]) begin
            o_out_inst1 = w_rdata1.inst;
            o_out_pc1   = w_rdata1.pc;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_count     = r_count;

`ifdef FETCHQ_PERF_EN
    logic [31:0] r_stall_cycles;

    // Counts cycles where fetch had work but the queue could not take it; survives flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
        end else if (i_in_valid[0] && !w_in_ready && !i_flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

`ifndef SYNTHESIS
    a_in_valid_legal : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_in_valid != 2'b10);
    a_out_take_legal : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_out_take != 2'b10) && ((i_out_take & ~w_out_valid) == 2'b00));
    a_count_bound    : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_inst0, in_inst1, in_pc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
    logic [1:0]  out_take;
    logic [3:0]  count;
`ifdef FETCHQ_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_in_inst0  (in_inst0),
        .i_in_inst1  (in_inst1),
        .i_in_pc     (in_pc),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_inst0 (out_inst0),
        .o_out_inst1 (out_inst1),
        .o_out_pc0   (out_pc0),
        .o_out_pc1   (out_pc1),
        .i_out_take  (out_take),
        .o_count     (count)
`ifdef FETCHQ_PERF_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain FIFO of {pc, inst} plus a stall tally.
    logic [63:0] mq[$];
    logic [31:0] m_stall;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  take;
        logic        fl;
        logic [3:0]  e_cnt;
        logic [1:0]  e_ov;
        logic        e_rdy;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic [31:0] e_inst0;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int sz;
        sz = mq.size();
        chk("model count", 32'(count), 32'(sz));
        chk("model out_valid", 32'(out_valid), {30'd0, sz >= 2, sz >= 1});
        chk("model in_ready", 32'(in_ready), 32'((DEPTH - sz) >= 2));
        chk("model pc0",   out_pc0,   (sz >= 1) ? mq[0][63:32] : 32'h0000_3000);
        chk("model inst0", out_inst0, (sz >= 1) ? mq[0][31:0]  : 32'h0);
        chk("model pc1",   out_pc1,   (sz >= 2) ? mq[1][63:32] : 32'h0000_3000);
        chk("model inst1", out_inst1, (sz >= 2) ? mq[1][31:0]  : 32'h0);
`ifdef FETCHQ_PERF_EN
        chk("model stall", stall_cycles, m_stall);
`endif
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare just after.
    task automatic tick(input logic [1:0] v, input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] take, input logic fl);
        int sz;
        int rd;
        bit rdy;
        in_valid = v; in_pc = pc; in_inst0 = i0; in_inst1 = i1; out_take = take; flush = fl;
        @(posedge clk);
        sz  = mq.size();
        rdy = (DEPTH - sz) >= 2;
        if (v[0] && !rdy && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            rd = (take == 2'b11) ? 2 : (take == 2'b01) ? 1 : 0;
            if (rd > sz) rd = sz;
            for (int k = 0; k < rd; k++) void'(mq.pop_front());
            if (rdy && v[0]) mq.push_back({pc, i0});
            if (rdy && v == 2'b11) mq.push_back({pc + 32'd4, i1});
        end
        #1;
        model_check();
    endtask

    function automatic logic [1:0] legal_take();
        int sz;
        int r;
        sz = mq.size();
        r  = $urandom_range(0, 2);
        if (sz == 0) return 2'b00;
        if (sz == 1) return (r == 0) ? 2'b00 : 2'b01;
        return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    endfunction

    initial begin
        int n_out;
        logic [1:0] tk;
        logic [1:0] rv;

        vt[0] = '{2'b11, 32'h3000, 32'hA, 32'hB, 2'b00, 1'b0, 4'd2, 2'b11, 1'b1, 32'h3000, 32'h3004, 32'hA};
        vt[1] = '{2'b00, 32'h0,    32'h0, 32'h0, 2'b00, 1'b0, 4'd2, 2'b11, 1'b1, 32'h3000, 32'h3004, 32'hA};
        vt[2] = '{2'b01, 32'h4000, 32'hC, 32'h0, 2'b01, 1'b0, 4'd2, 2'b11, 1'b1, 32'h3004, 32'h4000, 32'hB};
        vt[3] = '{2'b11, 32'h5000, 32'hD, 32'hE, 2'b11, 1'b0, 4'd2, 2'b11, 1'b1, 32'h5000, 32'h5004, 32'hD};
        vt[4] = '{2'b00, 32'h0,    32'h0, 32'h0, 2'b01, 1'b0, 4'd1, 2'b01, 1'b1, 32'h5004, 32'h3000, 32'hE};
        vt[5] = '{2'b00, 32'h0,    32'h0, 32'h0, 2'b01, 1'b0, 4'd0, 2'b00, 1'b1, 32'h3000, 32'h3000, 32'h0};
        vt[6] = '{2'b11, 32'hFFFF_FFFC, 32'hF, 32'h10, 2'b00, 1'b0, 4'd2, 2'b11, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hF};
        vt[7] = '{2'b00, 32'h0,    32'h0, 32'h0, 2'b11, 1'b0, 4'd0, 2'b00, 1'b1, 32'h3000, 32'h3000, 32'h0};
        vt[8] = '{2'b11, 32'h6000, 32'h1, 32'h2, 2'b00, 1'b1, 4'd0, 2'b00, 1'b1, 32'h3000, 32'h3000, 32'h0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 2'b00; in_pc = '0; in_inst0 = '0; in_inst1 = '0;
        out_take = 2'b00; m_stall = '0;
        #12;
        chk("reset count", 32'(count), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset pc0", out_pc0, 32'h3000);
        chk("reset inst0", out_inst0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            tick(vt[i].v, vt[i].pc, vt[i].i0, vt[i].i1, vt[i].take, vt[i].fl);
            chk("vec count", 32'(count), 32'(vt[i].e_cnt));
            chk("vec out_valid", 32'(out_valid), 32'(vt[i].e_ov));
            chk("vec in_ready", 32'(in_ready), 32'(vt[i].e_rdy));
            chk("vec pc0", out_pc0, vt[i].e_pc0);
            chk("vec pc1", out_pc1, vt[i].e_pc1);
            chk("vec inst0", out_inst0, vt[i].e_inst0);
        end

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 3; k++) tick(2'b11, 32'h7000 + 32'(8 * k), 32'h70 + 32'(k), 32'h71 + 32'(k), 2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst pc0", out_pc0, 32'h3000);
        mq.delete();
        m_stall = '0;
        in_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to DEPTH, then a held fifth pair must be ignored.
        for (int k = 0; k < 4; k++) tick(2'b11, 32'h8000 + 32'(8 * k), 32'h80 + 32'(k), 32'h90 + 32'(k), 2'b00, 1'b0);
        chk("full count", 32'(count), 32'd8);
        chk("full in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) tick(2'b11, 32'h9000, 32'hDEAD, 32'hBEEF, 2'b00, 1'b0);
        chk("full held count", 32'(count), 32'd8);
        chk("full held pc0", out_pc0, 32'h8000);
`ifdef FETCHQ_PERF_EN
        chk("stall cycles", stall_cycles, 32'd3);
`endif

        // Count=7: a write plus a double read is dropped on the write side.
        tick(2'b11, 32'h9000, 32'hDEAD, 32'hBEEF, 2'b01, 1'b0);
        chk("cnt7 count", 32'(count), 32'd7);
        chk("cnt7 in_ready", 32'(in_ready), 32'd0);
        tick(2'b11, 32'hA000, 32'hDEAD, 32'hBEEF, 2'b11, 1'b0);
        chk("cnt7 rw count", 32'(count), 32'd5);
        chk("cnt7 rw in_ready", 32'(in_ready), 32'd1);
        chk("cnt7 rw pc0", out_pc0, 32'h800C);
        tick(2'b00, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
        tick(2'b00, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0);
        chk("drain last pc0", out_pc0, 32'h801C);
        tick(2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0);
        chk("drain empty", 32'(count), 32'd0);

        // Stream 20 pairs through with continuous double reads; pointers wrap several times.
        n_out = 0;
        for (int i = 0; i <= 20; i++) begin
            tk = (mq.size() >= 2) ? 2'b11 : 2'b00;
            if (tk == 2'b11) begin
                chk("wrap pc0 order", out_pc0, 32'h3000 + 32'(4 * n_out));
                chk("wrap pc1 order", out_pc1, 32'h3000 + 32'(4 * n_out + 4));
                n_out += 2;
            end
            tick((i < 20) ? 2'b11 : 2'b00, 32'h3000 + 32'(8 * i), 32'h100 + 32'(i), 32'h200 + 32'(i), tk, 1'b0);
            chk("wrap count le2", 32'(count <= 4'd2), 32'd1);
        end
        chk("wrap total out", 32'(n_out), 32'd40);
        chk("wrap end empty", 32'(count), 32'd0);

        // Flush with reads and writes in the same cycle.
        for (int k = 0; k < 3; k++) tick(2'b11, 32'hB000 + 32'(8 * k), 32'hB0, 32'hB1, 2'b00, 1'b0);
        chk("preflush count", 32'(count), 32'd6);
        tick(2'b11, 32'hC000, 32'hC0, 32'hC1, 2'b11, 1'b1);
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        tick(2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
        chk("postflush count", 32'(count), 32'd0);
        chk("postflush pc0", out_pc0, 32'h3000);

        // Randomized legal traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            tk = legal_take();
            tick(rv, $urandom, $urandom, $urandom, tk, ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
